// File: rtl/mic_array_pkg.sv
// Shared types and constants for the microphone readout path.
package mic_array_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REQ,
      POP,
      LOAD,
      DONE
   } sched_state_e;

   localparam logic [7:0] HDR_SYNC  = 8'hA5;
   localparam int         MIC_IDX_W = 5;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by an edge register; rise/fall are one-cycle
// pulses. Registers reset high so an idle-high line produces no edge.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   always_ff @(posedge clk) begin
      if (!rst_n) sr <= 3'b111;
      else        sr <= {sr[1:0], din};
   end

   // sr[1] is the synchronized level, sr[2] its previous value
   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/mic_readout_sched.sv
// Readout scheduler: pops mic FIFOs round-robin, one byte per SPI request.
// Define MIC_SCHED_HEADER_EN to prefix each frame with sync + sequence bytes.
module mic_readout_sched
   import mic_array_pkg::*;
#(
   parameter int NUM_MICS  = 25,
   parameter int BIT_WIDTH = 8,
   parameter int ROUNDS    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ssel,
   input  logic                          data_needed,
   input  logic [NUM_MICS-1:0]           fifo_rdempty,
   input  logic [NUM_MICS*BIT_WIDTH-1:0] fifo_q,
   output logic [NUM_MICS-1:0]           fifo_rdreq,
   output logic [7:0]                    tx_byte,
   output logic                          tx_valid,
   output logic                          frame_active,
   output logic [MIC_IDX_W-1:0]          mic_idx,
   output logic [15:0]                   underrun_cnt
);

`ifdef MIC_SCHED_HEADER_EN
   localparam int HDR_BYTES = 2;
`else
   localparam int HDR_BYTES = 0;
`endif
   localparam int FRAME_LEN = NUM_MICS*ROUNDS + HDR_BYTES;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);

   sched_state_e     state, state_next;
   logic             ssel_rise, ssel_fall, dn_rise, dn_fall_unused;
   logic             open_frame, abort_frame, req_go, load_go, late_go;
   logic             req_empty, cur_empty, last_byte, hdr_phase;
   logic [7:0]       q_msb, hdr_byte;
   logic [CNT_W-1:0] byte_cnt;

   sync_edge_det u_ssel_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (ssel),
      .rise  (ssel_rise),
      .fall  (ssel_fall)
   );

   sync_edge_det u_dn_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (data_needed),
      .rise  (dn_rise),
      .fall  (dn_fall_unused)
   );

   // Per-mic select of the current sample MSBs and empty flag
   always_comb begin
      q_msb     = 8'h00;
      cur_empty = 1'b1;
      for (int i = 0; i < NUM_MICS; i++) begin
         if (mic_idx == MIC_IDX_W'(i)) begin
            q_msb     = fifo_q[i*BIT_WIDTH + BIT_WIDTH-8 +: 8];
            cur_empty = fifo_rdempty[i];
         end
      end
   end

   assign last_byte = (byte_cnt == CNT_W'(FRAME_LEN-1));

`ifdef MIC_SCHED_HEADER_EN
   logic [7:0] seq_cnt, frame_seq;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seq_cnt   <= 8'h00;
         frame_seq <= 8'h00;
      end else if (open_frame) begin
         frame_seq <= seq_cnt;
         seq_cnt   <= seq_cnt + 8'd1;
      end
   end

   assign hdr_phase = (byte_cnt < CNT_W'(HDR_BYTES));
   assign hdr_byte  = (byte_cnt == '0) ? HDR_SYNC : frame_seq;
`else
   assign hdr_phase = 1'b0;
   assign hdr_byte  = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // ssel rising edge aborts from any state, including a pending pop
   always_comb begin
      state_next  = state;
      open_frame  = 1'b0;
      abort_frame = 1'b0;
      req_go      = 1'b0;
      load_go     = 1'b0;
      late_go     = 1'b0;
      if (ssel_rise) begin
         state_next  = IDLE;
         abort_frame = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (ssel_fall) begin
                  state_next = WAIT_REQ;
                  open_frame = 1'b1;
               end
            end
            WAIT_REQ: begin
               if (dn_rise) begin
                  state_next = POP;
                  req_go     = 1'b1;
               end
            end
            POP: state_next = LOAD;
            LOAD: begin
               load_go    = 1'b1;
               state_next = last_byte ? DONE : WAIT_REQ;
            end
            DONE: late_go = dn_rise;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_rdreq   <= '0;
         tx_byte      <= 8'h00;
         tx_valid     <= 1'b0;
         frame_active <= 1'b0;
         mic_idx      <= '0;
         underrun_cnt <= 16'h0000;
         byte_cnt     <= '0;
         req_empty    <= 1'b0;
      end else begin
         fifo_rdreq <= '0;
         tx_valid   <= 1'b0;
         if (open_frame) begin
            mic_idx      <= '0;
            byte_cnt     <= '0;
            frame_active <= 1'b1;
         end
         if (abort_frame) frame_active <= 1'b0;
         if (req_go) begin
            req_empty <= cur_empty & ~hdr_phase;
            if (!cur_empty && !hdr_phase)
               fifo_rdreq <= NUM_MICS'(1) << mic_idx;
         end
         if (load_go) begin
            tx_valid <= 1'b1;
            byte_cnt <= byte_cnt + 1'b1;
            if (last_byte) frame_active <= 1'b0;
            if (hdr_phase) begin
               tx_byte <= hdr_byte;
            end else begin
               tx_byte <= req_empty ? 8'h00 : q_msb;
               if (req_empty && underrun_cnt != 16'hFFFF)
                  underrun_cnt <= underrun_cnt + 16'd1;
               mic_idx <= (mic_idx == MIC_IDX_W'(NUM_MICS-1)) ? '0 : mic_idx + 1'b1;
            end
         end
         // Requests past the frame end are padded without touching the FIFOs
         if (late_go) begin
            tx_byte  <= 8'h00;
            tx_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mic_readout_sched.sv
// Randomized bench for mic_readout_sched with a request-level behavioural model.
module tb_mic_readout_sched;

   localparam int N  = 25;
   localparam int BW = 8;
   localparam int R  = 4;
`ifdef MIC_SCHED_HEADER_EN
   localparam int HDR = 2;
`else
   localparam int HDR = 0;
`endif
   localparam int FLEN = N*R + HDR;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ssel = 1'b1;
   logic            data_needed = 1'b0;
   logic [N-1:0]    fifo_rdempty;
   logic [N*BW-1:0] fifo_q = '0;
   logic [N-1:0]    fifo_rdreq;
   logic [7:0]      tx_byte;
   logic            tx_valid, frame_active;
   logic [4:0]      mic_idx;
   logic [15:0]     underrun_cnt;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] empty_mask = '0;
   int           pop_cnt [N] = '{default: 0};
   bit           rnd_mode = 1'b0;
   int           seed;

   // Model: frame position, served mic, underruns, header sequence
   bit         m_open = 0, m_done = 0;
   int         m_nb = 0, m_mic = 0, m_under = 0, m_seq = 0, m_fseq = 0;
   logic [7:0] exp_bytes[$];
   int         exp_pop[$];

   assign fifo_rdempty = empty_mask;

   always #5 clk = ~clk;

   mic_readout_sched #(.NUM_MICS(N), .BIT_WIDTH(BW), .ROUNDS(R)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ssel         (ssel),
      .data_needed  (data_needed),
      .fifo_rdempty (fifo_rdempty),
      .fifo_q       (fifo_q),
      .fifo_rdreq   (fifo_rdreq),
      .tx_byte      (tx_byte),
      .tx_valid     (tx_valid),
      .frame_active (frame_active),
      .mic_idx      (mic_idx),
      .underrun_cnt (underrun_cnt)
   );

   function automatic logic [7:0] fsample(input int i, input int k);
      return rnd_mode ? 8'(i*37 + k*101 + seed) : 8'(i + 1);
   endfunction

   // FIFO model: data for a popped sample appears the cycle after rdreq
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (fifo_rdreq[i]) begin
            fifo_q[i*BW +: BW] <= fsample(i, pop_cnt[i]);
            pop_cnt[i]         <= pop_cnt[i] + 1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic compare_cycle();
      int m;
      logic [7:0] e;
      if (!rst_n) return;
      if (fifo_rdreq != '0) begin
         if (exp_pop.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rdreq_unexpected: got %b, no pop expected", fifo_rdreq);
         end else begin
            m = exp_pop.pop_front();
            check("rdreq_onehot", int'(fifo_rdreq), int'(N'(1) << m));
         end
      end
      if (tx_valid) begin
         if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte 0x%0h, no byte expected", tx_byte);
         end else begin
            e = exp_bytes.pop_front();
            check("tx_byte", int'(tx_byte), int'(e));
         end
      end
   endtask

   task automatic model_req();
      if (m_done) begin
         exp_bytes.push_back(8'h00);
      end else if (m_nb < HDR) begin
         exp_bytes.push_back(m_nb == 0 ? 8'hA5 : 8'(m_fseq));
         m_nb++;
      end else begin
         if (empty_mask[m_mic]) begin
            exp_bytes.push_back(8'h00);
            if (m_under < 65535) m_under++;
         end else begin
            exp_bytes.push_back(fsample(m_mic, pop_cnt[m_mic]));
            exp_pop.push_back(m_mic);
         end
         m_mic = (m_mic + 1) % N;
         m_nb++;
      end
      if (m_nb == FLEN) m_done = 1;
   endtask

   task automatic check_state();
      check("mic_idx", int'(mic_idx), m_mic);
      check("frame_active", int'(frame_active), int'(m_open && !m_done));
      check("underrun_cnt", int'(underrun_cnt), m_under);
      check("pops_issued", exp_pop.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rdreq"}, int'(fifo_rdreq), 0);
      check({tag, "_tx_byte"}, int'(tx_byte), 0);
      check({tag, "_tx_valid"}, int'(tx_valid), 0);
      check({tag, "_frame_active"}, int'(frame_active), 0);
      check({tag, "_mic_idx"}, int'(mic_idx), 0);
      check({tag, "_underrun"}, int'(underrun_cnt), 0);
   endtask

   task automatic request(output int lat, output logic [7:0] got);
      model_req();
      @(posedge clk); #1 data_needed = 1'b1;
      lat = 0;
      while (lat < 20 && !tx_valid) begin
         @(posedge clk); #1;
         lat++;
      end
      got = tx_byte;
      check("req_byte_seen", int'(tx_valid), 1);
      @(negedge clk); #1;
      check("byte_queue_drained", exp_bytes.size(), 0);
      exp_bytes.delete();
      data_needed = 1'b0;
      repeat (4) @(posedge clk);
      #1 check_state();
   endtask

   task automatic open_frame();
      @(posedge clk); #1 ssel = 1'b0;
      m_open = 1; m_done = 0; m_nb = 0; m_mic = 0;
      m_fseq = m_seq;
      m_seq  = (m_seq + 1) % 256;
      repeat (5) @(posedge clk);
      #1;
      check("open_frame_active", int'(frame_active), 1);
      check("open_mic_idx", int'(mic_idx), 0);
   endtask

   task automatic close_frame();
      @(posedge clk); #1 ssel = 1'b1;
      m_open = 0;
      repeat (5) @(posedge clk);
      #1 check("close_frame_active", int'(frame_active), 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int lat;
      int p3;
      int t;
      logic [7:0] b;
      seed = int'($urandom);
      fork
         forever begin
            @(negedge clk);
            compare_cycle();
         end
      join_none

      repeat (3) @(posedge clk);
      #1 check_reset("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Frame A: every mic holds i+1, all FIFOs non-empty
      open_frame();
      for (int k = 0; k < FLEN; k++) begin
         request(lat, b);
         if (k == 0)       check("first_latency", lat, 5);
         if (k == HDR)     check("first_mic_byte", int'(b), 1);
         if (k == HDR+24)  check("last_mic_byte", int'(b), 25);
         if (k == HDR+25)  check("round2_byte", int'(b), 1);
`ifdef MIC_SCHED_HEADER_EN
         if (k == 0) check("hdr_sync_f0", int'(b), 'hA5);
         if (k == 1) check("hdr_seq_f0", int'(b), 0);
`endif
      end
      check("frameA_done", int'(frame_active), 0);
      check("frameA_pops_mic0", pop_cnt[0], R);

      // Request after the frame is complete
      request(lat, b);
      check("done_byte", int'(b), 0);
      check("done_underrun", int'(underrun_cnt), 0);
      close_frame();

      // Frame B: mic 3 empty throughout
      empty_mask[3] = 1'b1;
      p3 = pop_cnt[3];
      open_frame();
      for (int k = 0; k < FLEN; k++) begin
         request(lat, b);
         if (k == HDR+3)  check("empty_mic3_byte", int'(b), 0);
         if (k == HDR+78) check("empty_mic3_byte_r4", int'(b), 0);
`ifdef MIC_SCHED_HEADER_EN
         if (k == 0) check("hdr_sync_f1", int'(b), 'hA5);
         if (k == 1) check("hdr_seq_f1", int'(b), 1);
`endif
      end
      check("frameB_underrun", int'(underrun_cnt), 4);
      check("frameB_no_pop3", pop_cnt[3] - p3, 0);
      empty_mask = '0;
      close_frame();

      // Random data and empty patterns, abort mid-frame with a pop in flight
      rnd_mode = 1'b1;
      open_frame();
      for (int k = 0; k < 10 + HDR; k++) begin
         empty_mask = N'($urandom & $urandom);
         request(lat, b);
      end
      empty_mask[m_mic] = 1'b0;
      exp_pop.push_back(m_mic);
      @(posedge clk); #1 data_needed = 1'b1;
      @(posedge clk); #1 ssel = 1'b1;
      m_open = 0;
      repeat (6) @(posedge clk);
      #1;
      check("abort_frame_active", int'(frame_active), 0);
      check("abort_pop_seen", exp_pop.size(), 0);
      exp_pop.delete();
      data_needed = 1'b0;
      repeat (4) @(posedge clk);
      open_frame();
      for (int k = 0; k < 40; k++) begin
         empty_mask = N'($urandom & $urandom);
         request(lat, b);
      end
      close_frame();

      // Reset asserted while a pop is on the FIFO interface
      rnd_mode   = 1'b0;
      empty_mask = '0;
      open_frame();
      for (int k = 0; k < HDR; k++) request(lat, b);
      exp_pop.push_back(m_mic);
      @(posedge clk); #1 data_needed = 1'b1;
      t = 0;
      @(negedge clk);
      while (t < 20 && fifo_rdreq == '0) begin
         @(negedge clk);
         t++;
      end
      check("pop_before_reset", int'(fifo_rdreq != '0), 1);
      #1;
      rst_n = 1'b0;
      ssel = 1'b1;
      data_needed = 1'b0;
      @(posedge clk); #1;
      check_reset("reset_in_pop");
      check("reset_pop_seen", exp_pop.size(), 0);
      exp_pop.delete();
      exp_bytes.delete();
      m_open = 0; m_done = 0; m_under = 0; m_seq = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      open_frame();
      request(lat, b);
`ifdef MIC_SCHED_HEADER_EN
      check("post_reset_sync", int'(b), 'hA5);
      request(lat, b);
      check("post_reset_seq", int'(b), 0);
      request(lat, b);
`endif
      check("post_reset_mic0", int'(b), 1);
      close_frame();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mic_readout_sched.md
# mic_readout_sched

Readout scheduler between the per-microphone sample FIFOs and the SPI slave byte interface. It opens a readout frame on each falling edge of SPI slave select. For every byte the SPI slave requests, it pops one sample from the microphone FIFOs in round-robin order and presents the byte for transmission. It owns mic sequencing, empty-FIFO substitution, frame-length limiting and underrun accounting; the FIFOs and the SPI shifter are unchanged.

## Interface
- NUM_MICS, 25, number of microphone FIFOs (2..32)
- BIT_WIDTH, 8, FIFO sample width; must be >= 8
- ROUNDS, 4, full passes over all mics per frame
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- ssel  input  1  SPI slave select, asynchronous; 2-FF synchronized internally
- data_needed  input  1  SPI slave byte-request level; rising edge = one request
- fifo_rdempty  input  NUM_MICS  per-mic FIFO empty flags
- fifo_q  input  NUM_MICS*BIT_WIDTH  FIFO read data, mic i at [i*BIT_WIDTH +: BIT_WIDTH]; valid the cycle after rdreq
- fifo_rdreq  output  NUM_MICS  one-hot pop strobe, single-cycle
- tx_byte  output  8  byte for the SPI slave (dataToSend)
- tx_valid  output  1  one-cycle pulse when tx_byte updates
- frame_active  output  1  high from frame open until frame done or abort
- mic_idx  output  5  mic to be served by the next request
- underrun_cnt  output  16  saturating count of empty-FIFO substitutions since reset

## Operation
- States: IDLE, WAIT_REQ, POP, LOAD, DONE.
- IDLE: on a synchronized ssel falling edge:
  - clear mic_idx and the byte counter;
  - set frame_active;
  - go to WAIT_REQ.
- WAIT_REQ: on a data_needed rising edge:
  - if fifo_rdempty[mic_idx]=0, assert fifo_rdreq[mic_idx] and go to POP;
  - else go to POP with no strobe and mark the request empty.
- POP: go to LOAD unconditionally.
- LOAD:
  - tx_byte = fifo_q[mic_idx*BIT_WIDTH + BIT_WIDTH-1 -: 8] (8 MSBs), or 0x00 if the request was marked empty; then underrun_cnt += 1, saturating at 0xFFFF;
  - pulse tx_valid;
  - advance mic_idx, wrapping NUM_MICS-1 -> 0;
  - increment the byte counter.
  - If the byte counter reaches NUM_MICS*ROUNDS (plus header bytes when configured), go to DONE; else go to WAIT_REQ.
- DONE:
  - clear frame_active;
  - each further request produces tx_byte=0x00 with tx_valid and no pop;
  - underrun_cnt is unchanged.
- Any state: a synchronized ssel rising edge returns to IDLE on the next cycle.
  - An in-flight pop's data is discarded.
  - tx_byte holds its last value.
- data_needed edges arriving in POP or LOAD are ignored. SPI byte periods greatly exceed 3 clk cycles.
- Simultaneous ssel falling edge and data_needed edge: the frame opens and the request is ignored.

## Timing
- Reset values: fifo_rdreq=0, tx_byte=0x00, tx_valid=0, frame_active=0, mic_idx=0, underrun_cnt=0. State resets to IDLE and the edge/sync registers to 1 (ssel idle high, no spurious edge).
- data_needed edge detection costs 3 cycles: 2-FF sync plus an edge register. ssel uses the same path.
- Cycle E is the cycle the edge is registered:
  - fifo_rdreq is high during E+1 (POP);
  - fifo_q is sampled at the end of E+2;
  - tx_byte and tx_valid are valid at E+3.
- Request-to-byte latency is 3 cycles after detection.
- At most one pop per request, and never more than one bit of fifo_rdreq high.
- rst_n low mid-frame: all outputs return to reset values on the next clk edge; a pending pop is abandoned.

## Configuration
- MIC_SCHED_HEADER_EN defined: each frame starts with 2 header bytes before the mic data:
  - 0xA5 sync;
  - 8-bit frame sequence number, incremented per opened frame, wrapping 0xFF -> 0x00, reset 0.
  - Header bytes cause no pops. Frame length is NUM_MICS*ROUNDS+2, and mic_idx stays 0 during the header.
- MIC_SCHED_HEADER_EN undefined: no header. The frame is NUM_MICS*ROUNDS mic bytes and no sequence register exists.

## Structure
- Shared package mic_array_pkg holds:
  - the state enum typedef;
  - HDR_SYNC = 8'hA5;
  - the MIC_IDX_W = 5 constant.
- One sub-module, sync_edge_det: 2-FF synchronizer plus rising/falling edge pulses. It is instantiated twice, for ssel and data_needed.

## Test plan
- Reset, then ssel falls, then 100 requests with all FIFOs non-empty and mic i holding 8'(i+1): tx_byte sequence 1..25 repeated 4 times; each fifo_rdreq pulse is one-hot and matches the sequence; frame_active drops after byte 100.
- FIFO 3 empty throughout the frame: bytes at positions 3, 28, 53, 78 are 0x00 with no rdreq[3]; underrun_cnt = 4.
- 101st request after DONE: tx_byte = 0x00 with tx_valid, no pop, underrun_cnt unchanged.
- ssel rises after 10 bytes, then falls again: the next byte comes from mic 0; the state passed through IDLE; the aborted pop's data never appears.
- rst_n asserted during POP: the next cycle shows all outputs at reset values and fifo_rdreq = 0.
- MIC_SCHED_HEADER_EN defined, two frames: the first bytes are A5,00 then A5,01; mic data follows unchanged; frame length is 102.
